// File: rtl/simd_alu_pipe.sv
// ============================================================================
// simd_alu_pipe : two-stage packed-SIMD ALU with element select and sticky ovf
// Revision 1.0
// ============================================================================
`default_nettype none

module simd_alu_pipe #(
    parameter int DATA_W = 128,
    parameter int SAT_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] reg_A,
    input  logic [DATA_W-1:0] reg_B,
    input  logic [2:0]        ctrl_ppp,
    input  logic [1:0]        ctrl_ww,
    input  logic [2:0]        alu_op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              ovf,
    input  logic              ovf_clr
);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_NOT  = 3'b101;
    localparam logic [2:0] OP_SADD = 3'b110;
    localparam logic [2:0] OP_SSUB = 3'b111;

    logic              s1_valid;
    logic [DATA_W-1:0] s1_a;
    logic [DATA_W-1:0] s1_b;
    logic [2:0]        s1_ppp;
    logic [1:0]        s1_ww;
    logic [2:0]        s1_op;
    logic              s2_ovf;

    logic                   s2_adv;
    logic [3:0][DATA_W-1:0] res_by_w;
    logic [3:0]             ovf_by_w;
    logic [DATA_W-1:0]      next_result;
    logic                   next_ovf;

    assign s2_adv   = ~out_valid | out_ready;
    assign in_ready = ~s1_valid | s2_adv;

    // Every element width is evaluated in parallel; ctrl_ww picks one afterwards.
    // Element 0 sits at the MSB end of the vector.
    for (genvar w = 0; w < 4; w++) begin : g_width
        localparam int EW = 8 << w;
        localparam int NE = DATA_W / EW;
        logic [DATA_W-1:0] res_vec;
        logic [NE-1:0]     ov_vec;

        for (genvar e = 0; e < NE; e++) begin : g_elem
            localparam int LO = DATA_W - (e + 1) * EW;
            logic [EW-1:0] a;
            logic [EW-1:0] b;
            logic [EW-1:0] op_res;
            logic [EW:0]   sum;
            logic [EW:0]   diff;
            logic          sel;
            logic          op_ov;

            assign a    = s1_a[LO +: EW];
            assign b    = s1_b[LO +: EW];
            assign sum  = {1'b0, a} + {1'b0, b};
            assign diff = {1'b0, a} - {1'b0, b};

            always_comb begin
                sel = 1'b0;
                case (s1_ppp)
                    3'b000:  sel = 1'b1;
                    3'b001:  sel = (e < NE / 2);
                    3'b010:  sel = (e >= NE / 2);
                    3'b011:  sel = (e % 2 == 0);
                    3'b100:  sel = (e % 2 == 1);
                    default: sel = 1'b0;
                endcase
            end

            always_comb begin
                op_res = a;
                op_ov  = 1'b0;
                case (s1_op)
                    OP_ADD:  begin op_res = sum[EW-1:0];  op_ov = sum[EW];  end
                    OP_SUB:  begin op_res = diff[EW-1:0]; op_ov = diff[EW]; end
                    OP_AND:  op_res = a & b;
                    OP_OR:   op_res = a | b;
                    OP_XOR:  op_res = a ^ b;
                    OP_NOT:  op_res = ~a;
                    OP_SADD: begin
                        op_res = (sum[EW] && SAT_EN != 0) ? '1 : sum[EW-1:0];
                        op_ov  = sum[EW];
                    end
                    OP_SSUB: begin
                        op_res = (diff[EW] && SAT_EN != 0) ? '0 : diff[EW-1:0];
                        op_ov  = diff[EW];
                    end
                    default: begin op_res = a; op_ov = 1'b0; end
                endcase
            end

            assign res_vec[LO +: EW] = sel ? op_res : a;
            assign ov_vec[e]         = sel & op_ov;
        end

        assign res_by_w[w] = res_vec;
        assign ovf_by_w[w] = |ov_vec;
    end

    assign next_result = res_by_w[s1_ww];
    assign next_ovf    = ovf_by_w[s1_ww];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_ppp    <= '0;
            s1_ww     <= '0;
            s1_op     <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            s2_ovf    <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            if (s2_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    result <= next_result;
                    s2_ovf <= next_ovf;
                end
            end
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_a   <= reg_A;
                    s1_b   <= reg_B;
                    s1_ppp <= ctrl_ppp;
                    s1_ww  <= ctrl_ww;
                    s1_op  <= alu_op;
                end
            end
            // A flagged transfer beats a same-cycle clear.
            if (out_valid && out_ready && s2_ovf) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_simd_alu_pipe.sv
// ============================================================================
// tb_simd_alu_pipe : scoreboard bench with random and directed SIMD ALU traffic
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_simd_alu_pipe;

    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] reg_A = '0;
    logic [DW-1:0] reg_B = '0;
    logic [2:0]    ctrl_ppp = '0;
    logic [1:0]    ctrl_ww = '0;
    logic [2:0]    alu_op = '0;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] result;
    logic          ovf;
    logic          ovf_clr;

    typedef struct {
        logic [DW-1:0] r;
        logic          o;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   issued = 0;
    int   popped = 0;
    logic model_ovf = 1'b0;
    bit   rand_ready = 1'b0;
    bit   rand_clr = 1'b0;
    logic ready_force = 1'b1;
    logic clr_force = 1'b0;
    bit   saw_stall = 1'b0;

    simd_alu_pipe #(.DATA_W(DW), .SAT_EN(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .reg_A(reg_A), .reg_B(reg_B), .ctrl_ppp(ctrl_ppp), .ctrl_ww(ctrl_ww),
        .alu_op(alu_op), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .ovf(ovf), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [DW-1:0] r, input logic o);
        exp_t x;
        x.r = r;
        x.o = o;
        return x;
    endfunction

    // Reference: per-element unsigned arithmetic on integers, element 0 at the MSB end.
    function automatic exp_t model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                   input logic [2:0] ppp, input logic [1:0] ww, input logic [2:0] op);
        exp_t          x;
        int            ew;
        int            n;
        int            lo;
        logic [64:0]   full, mask, ae, be, r;
        logic [DW-1:0] tmp, m_wide, r_wide;
        bit            sel, ov;
        ew   = 8 << ww;
        n    = DW / ew;
        full = 65'd1 << ew;
        mask = full - 65'd1;
        x.r  = a;
        x.o  = 1'b0;
        for (int e = 0; e < n; e++) begin
            lo  = DW - (e + 1) * ew;
            tmp = a >> lo;
            ae  = {1'b0, tmp[63:0]} & mask;
            tmp = b >> lo;
            be  = {1'b0, tmp[63:0]} & mask;
            case (ppp)
                3'd0:    sel = 1'b1;
                3'd1:    sel = (e < n / 2);
                3'd2:    sel = (e >= n / 2);
                3'd3:    sel = (e % 2 == 0);
                3'd4:    sel = (e % 2 == 1);
                default: sel = 1'b0;
            endcase
            ov = 1'b0;
            case (op)
                3'd0: begin r = ae + be; ov = (r >= full); r = r & mask; end
                3'd1: begin ov = (ae < be); r = (ae + full - be) & mask; end
                3'd2: r = ae & be;
                3'd3: r = ae | be;
                3'd4: r = ae ^ be;
                3'd5: r = ~ae & mask;
                3'd6: begin ov = (ae + be >= full); r = ov ? mask : ((ae + be) & mask); end
                default: begin ov = (ae < be); r = ov ? 65'd0 : (ae - be); end
            endcase
            if (sel) begin
                m_wide = '0;
                r_wide = '0;
                m_wide[64:0] = mask;
                r_wide[64:0] = r;
                x.r = (x.r & ~(m_wide << lo)) | (r_wide << lo);
                x.o = x.o | ov;
            end
        end
        return x;
    endfunction

    function automatic logic [DW-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic issue(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [2:0] ppp,
                         input logic [1:0] ww, input logic [2:0] op, input exp_t e);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        reg_A    = a;
        reg_B    = b;
        ctrl_ppp = ppp;
        ctrl_ww  = ww;
        alu_op   = op;
        in_valid = 1'b1;
        @(negedge clk);
        while (in_ready !== 1'b1) begin
            saw_stall = 1'b1;
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL issue_timeout: in_ready got %b expected 1", in_ready);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        sb.push_back(e);
        issued++;
    endtask

    task automatic issue_model(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [2:0] ppp,
                               input logic [1:0] ww, input logic [2:0] op);
        issue(a, b, ppp, ww, op, model(a, b, ppp, ww, op));
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        reg_A    = rnd128();
        reg_B    = rnd128();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_int("drain_queue_empty", sb.size(), 0);
    endtask

    // Monitor: compares each transferred result and tracks the sticky flag.
    initial begin
        exp_t x;
        logic set;
        forever begin
            @(negedge clk);
            if (reset) begin
                sb.delete();
                model_ovf = 1'b0;
            end else begin
                check("ovf", {{(DW-1){1'b0}}, ovf}, {{(DW-1){1'b0}}, model_ovf});
                set = 1'b0;
                if (out_valid === 1'b1 && out_ready === 1'b1) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got %h expected none", result);
                    end else begin
                        x = sb.pop_front();
                        popped++;
                        check("result", result, x.r);
                        set = x.o;
                    end
                end
                if (set) model_ovf = 1'b1;
                else if (ovf_clr) model_ovf = 1'b0;
            end
        end
    end

    initial begin
        out_ready = 1'b1;
        ovf_clr   = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            out_ready = rand_ready ? ($urandom % 10 < 7) : ready_force;
            ovf_clr   = rand_clr ? ($urandom % 8 == 0) : clr_force;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time got 500000 expected completion earlier");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] a35, b35, a37, b37;
        a35 = {{15{8'hff}}, 8'hf9};
        b35 = {{15{8'h00}}, 8'h08};
        a37 = {8{16'h0001}};
        b37 = {8{16'h0002}};

        // Asynchronous reset with no clock edge yet.
        #2 reset = 1'b1;
        #1;
        check("reset_out_valid", {{(DW-1){1'b0}}, out_valid}, '0);
        check("reset_ovf", {{(DW-1){1'b0}}, ovf}, '0);
        check("reset_result", result, '0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("in_ready_after_reset", {{(DW-1){1'b0}}, in_ready}, {{(DW-1){1'b0}}, 1'b1});

        issue(128'h0102030405060708090a0b0c0d0e0f10, 128'h01020304010203040507070809050607,
              3'b000, 2'b00, 3'b000, mk(128'h0204060806080a0c0e11121416131517, 1'b0));
        issue(a35, b35, 3'b000, 2'b00, 3'b000, mk({{15{8'hff}}, 8'h01}, 1'b1));
        issue(a35, b35, 3'b000, 2'b00, 3'b110, mk({16{8'hff}}, 1'b1));
        issue(128'h00000001000000020000000300000004, 128'h00000005000000060000000700000008,
              3'b001, 2'b10, 3'b000, mk(128'h00000006000000080000000300000004, 1'b0));
        issue(a37, b37, 3'b011, 2'b01, 3'b111, mk({4{16'h0000, 16'h0001}}, 1'b1));
        issue(128'h0102030405060708090a0b0c0d0e0f10, 128'h01020304010203040507070809050607,
              3'b101, 2'b00, 3'b000, mk(128'h0102030405060708090a0b0c0d0e0f10, 1'b0));
        issue(a35, b35, 3'b010, 2'b11, 3'b000, mk({64'hffffffffffffffff, 64'h1}, 1'b1));
        idle();
        drain();

        // Clear the sticky flag with no transfer in flight.
        @(posedge clk);
        #1 clr_force = 1'b1;
        @(posedge clk);
        #1 clr_force = 1'b0;
        @(negedge clk);
        check("ovf_after_clr", {{(DW-1){1'b0}}, ovf}, '0);

        // Four-op stream with a three-cycle downstream stall.
        saw_stall = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++)
                    issue_model(rnd128(), rnd128(), 3'b000, 2'($urandom_range(0, 3)), 3'b000);
                idle();
            end
            begin
                repeat (2) @(posedge clk);
                #1 ready_force = 1'b0;
                repeat (3) @(posedge clk);
                #1 ready_force = 1'b1;
            end
        join
        drain();
        check_int("stall_in_ready_dropped", int'(saw_stall), 1);
        check_int("stream_count", popped, issued);

        // Random traffic with random backpressure and occasional clears.
        @(posedge clk);
        #1;
        rand_ready = 1'b1;
        rand_clr   = 1'b1;
        for (int i = 0; i < 300; i++)
            issue_model(rnd128(), rnd128(), 3'($urandom_range(0, 7)),
                        2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
        idle();
        #1;
        rand_ready = 1'b0;
        rand_clr   = 1'b0;
        drain();
        check_int("random_count", popped, issued);

        // Reset with two operations in flight behind a stalled output.
        issue(a35, b35, 3'b000, 2'b00, 3'b000, mk({{15{8'hff}}, 8'h01}, 1'b1));
        idle();
        drain();
        @(posedge clk);
        #1 ready_force = 1'b0;
        issue_model(rnd128(), rnd128(), 3'b000, 2'b00, 3'b000);
        issue_model(rnd128(), rnd128(), 3'b000, 2'b01, 3'b001);
        idle();
        #3;
        check("pre_reset_out_valid", {{(DW-1){1'b0}}, out_valid}, {{(DW-1){1'b0}}, 1'b1});
        check("pre_reset_ovf", {{(DW-1){1'b0}}, ovf}, {{(DW-1){1'b0}}, 1'b1});
        reset = 1'b1;
        #1;
        check("async_reset_out_valid", {{(DW-1){1'b0}}, out_valid}, '0);
        check("async_reset_ovf", {{(DW-1){1'b0}}, ovf}, '0);
        check("async_reset_result", result, '0);
        @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        ready_force = 1'b1;
        check("in_ready_after_release", {{(DW-1){1'b0}}, in_ready}, {{(DW-1){1'b0}}, 1'b1});
        repeat (10) @(posedge clk);
        #1;
        check("no_stale_output", {{(DW-1){1'b0}}, out_valid}, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
